// File: rtl/board_occupancy_tracker_if.sv
// Move handshake between a player front-end (master) and the board tracker (slave).
interface board_occupancy_tracker_if #(
    parameter int BOARD_DIM = 4
);
    localparam int CELLS = BOARD_DIM * BOARD_DIM;
    localparam int IDX_W = $clog2(CELLS);

    logic             move_valid;
    logic [IDX_W-1:0] move_idx;
    logic [1:0]       move_player;
    logic             move_ready;
    logic             move_ack;
    logic             move_err;
    logic [1:0]       err_code;

    modport master (
        output move_valid, move_idx, move_player,
        input  move_ready, move_ack, move_err, err_code
    );

    modport slave (
        input  move_valid, move_idx, move_player,
        output move_ready, move_ack, move_err, err_code
    );
endinterface

// File: rtl/board_occupancy_tracker.sv
// Registered N x N tic-tac-toe board store: legality check, turn order, occupancy count, full flag.
// Define TRACKER_UNDO_EN to build the one-deep undo history driven by undo_req.
module board_occupancy_tracker #(
    parameter int BOARD_DIM = 4
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  clear,
    input  logic                                  undo_req,
    board_occupancy_tracker_if.slave              mv,
    output logic [2*BOARD_DIM*BOARD_DIM-1:0]      board,
    output logic [$clog2(BOARD_DIM*BOARD_DIM):0]  occupied_cnt,
    output logic [1:0]                            turn,
    output logic                                  no_space
);
    localparam int CELLS = BOARD_DIM * BOARD_DIM;
    localparam int IDX_W = $clog2(CELLS);
    localparam logic [IDX_W:0] CELLS_C = (IDX_W + 1)'(CELLS);
    localparam logic [IDX_W:0] CNT_ONE = (IDX_W + 1)'(1);

    localparam logic [1:0] PL_X     = 2'b01;
    localparam logic [1:0] PL_O     = 2'b10;
    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OCC  = 2'b01;
    localparam logic [1:0] ERR_TURN = 2'b10;
    localparam logic [1:0] ERR_BAD  = 2'b11;

    typedef enum logic [1:0] {IDLE, CHECK, COMMIT, FULL} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       player_q;
    logic             ready_q;
    logic             ack_q;
    logic             err_q;
    logic [1:0]       code_q;
    logic [1:0]       check_code;
    logic [IDX_W:0]   cnt_inc;

    function automatic logic [1:0] cell_at(input logic [2*CELLS-1:0] b,
                                           input logic [IDX_W-1:0]   idx);
        logic [1:0] v;
        v = 2'b00;
        for (int k = 0; k < CELLS; k++)
            if (idx == IDX_W'(k)) v = b[2*k +: 2];
        return v;
    endfunction

    function automatic logic [2*CELLS-1:0] cell_write(input logic [2*CELLS-1:0] b,
                                                      input logic [IDX_W-1:0]   idx,
                                                      input logic [1:0]         val);
        logic [2*CELLS-1:0] r;
        r = b;
        for (int k = 0; k < CELLS; k++)
            if (idx == IDX_W'(k)) r[2*k +: 2] = val;
        return r;
    endfunction

    // Rejection reasons in fixed priority: malformed request, wrong turn, occupied cell.
    function automatic logic [1:0] judge(input logic [IDX_W-1:0]   idx,
                                         input logic [1:0]         pl,
                                         input logic [1:0]         trn,
                                         input logic [2*CELLS-1:0] b);
        logic [1:0] c;
        c = ERR_NONE;
        if ({1'b0, idx} >= CELLS_C || pl == 2'b00 || pl == 2'b11) c = ERR_BAD;
        else if (pl != trn)                                        c = ERR_TURN;
        else if (cell_at(b, idx) != 2'b00)                         c = ERR_OCC;
        return c;
    endfunction

    function automatic logic [1:0] other(input logic [1:0] p);
        return (p == PL_X) ? PL_O : PL_X;
    endfunction

    assign check_code = judge(idx_q, player_q, turn, board);
    assign cnt_inc    = occupied_cnt + CNT_ONE;

`ifdef TRACKER_UNDO_EN
    logic [IDX_W-1:0] hist_idx;
    logic             hist_vld;
`else
    logic unused_undo;
    assign unused_undo = undo_req;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            board        <= '0;
            occupied_cnt <= '0;
            turn         <= PL_X;
            no_space     <= 1'b0;
            idx_q        <= '0;
            player_q     <= 2'b00;
            ready_q      <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            code_q       <= ERR_NONE;
`ifdef TRACKER_UNDO_EN
            hist_idx     <= '0;
            hist_vld     <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (clear) begin
                // New game: any move in flight is dropped without a response.
                state        <= IDLE;
                board        <= '0;
                occupied_cnt <= '0;
                turn         <= PL_X;
                no_space     <= 1'b0;
                code_q       <= ERR_NONE;
                ready_q      <= 1'b1;
`ifdef TRACKER_UNDO_EN
                hist_vld     <= 1'b0;
`endif
            end
`ifdef TRACKER_UNDO_EN
            else if (undo_req && (state == IDLE || state == FULL)) begin
                if (hist_vld) begin
                    board        <= cell_write(board, hist_idx, 2'b00);
                    occupied_cnt <= occupied_cnt - CNT_ONE;
                    turn         <= other(turn);
                    no_space     <= 1'b0;
                    state        <= IDLE;
                    ready_q      <= 1'b1;
                    hist_vld     <= 1'b0;
                    ack_q        <= 1'b1;
                    code_q       <= ERR_NONE;
                end else begin
                    err_q   <= 1'b1;
                    code_q  <= ERR_BAD;
                    ready_q <= (state == IDLE);
                end
            end
`endif
            else begin
                case (state)
                    IDLE: begin
                        ready_q <= 1'b1;
                        if (mv.move_valid && ready_q) begin
                            idx_q    <= mv.move_idx;
                            player_q <= mv.move_player;
                            ready_q  <= 1'b0;
                            state    <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (check_code != ERR_NONE) begin
                            err_q   <= 1'b1;
                            code_q  <= check_code;
                            ready_q <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            state <= COMMIT;
                        end
                    end
                    COMMIT: begin
                        board        <= cell_write(board, idx_q, player_q);
                        occupied_cnt <= cnt_inc;
                        turn         <= other(turn);
                        ack_q        <= 1'b1;
                        code_q       <= ERR_NONE;
`ifdef TRACKER_UNDO_EN
                        hist_idx     <= idx_q;
                        hist_vld     <= 1'b1;
`endif
                        if (cnt_inc == CELLS_C) begin
                            no_space <= 1'b1;
                            ready_q  <= 1'b0;
                            state    <= FULL;
                        end else begin
                            ready_q <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                    FULL: begin
                        ready_q <= 1'b0;
                    end
                    default: begin
                        ready_q <= 1'b0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

    assign mv.move_ready = ready_q;
    assign mv.move_ack   = ack_q;
    assign mv.move_err   = err_q;
    assign mv.err_code   = code_q;
endmodule

// File: tb/tb_board_occupancy_tracker.sv
// Scoreboard bench for board_occupancy_tracker: a 4x4 instance and a 3x3 instance on one clock.
module tb_board_occupancy_tracker;
    localparam logic [1:0] X = 2'b01;
    localparam logic [1:0] O = 2'b10;

    logic clock;
    logic reset;
    logic clear4, clear3, undo4, undo3;
    logic [31:0] board4;
    logic [17:0] board3;
    logic [4:0]  cnt4, cnt3;
    logic [1:0]  turn4, turn3;
    logic        ns4, ns3;

    board_occupancy_tracker_if #(.BOARD_DIM(4)) bus4 ();
    board_occupancy_tracker_if #(.BOARD_DIM(3)) bus3 ();

    board_occupancy_tracker #(.BOARD_DIM(4)) dut4 (
        .clock(clock), .reset(reset), .clear(clear4), .undo_req(undo4), .mv(bus4.slave),
        .board(board4), .occupied_cnt(cnt4), .turn(turn4), .no_space(ns4));

    board_occupancy_tracker #(.BOARD_DIM(3)) dut3 (
        .clock(clock), .reset(reset), .clear(clear3), .undo_req(undo3), .mv(bus3.slave),
        .board(board3), .occupied_cnt(cnt3), .turn(turn3), .no_space(ns3));

    typedef struct {
        logic        is_ack;
        logic [1:0]  code;
        int          lat;
        int          hs;
        logic [63:0] brd;
        int          cnt;
        logic        ns;
        logic [1:0]  trn;
    } exp_t;

    exp_t q4[$];
    exp_t q3[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int resp_cnt [2];

    logic [1:0] mb [2][64];
    int         mcnt [2];
    logic [1:0] mturn [2];
    int         mlast [2];
    logic       mhist [2];

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ncells(input int d);
        return (d == 0) ? 16 : 9;
    endfunction

    function automatic logic [63:0] pack(input int d);
        logic [63:0] b;
        b = '0;
        for (int k = 0; k < ncells(d); k++) b[2*k +: 2] = mb[d][k];
        return b;
    endfunction

    function automatic logic rdy(input int d);
        return (d == 0) ? bus4.move_ready : bus3.move_ready;
    endfunction

    task automatic reset_model(input int d);
        for (int k = 0; k < 64; k++) mb[d][k] = 2'b00;
        mcnt[d]  = 0;
        mturn[d] = X;
        mlast[d] = 0;
        mhist[d] = 1'b0;
    endtask

    task automatic snap(input int d, inout exp_t e);
        e.brd = pack(d);
        e.cnt = mcnt[d];
        e.ns  = (mcnt[d] == ncells(d));
        e.trn = mturn[d];
    endtask

    task automatic drive(input int d, input logic v, input int idx, input logic [1:0] pl);
        logic [3:0] i4;
        i4 = idx[3:0];
        if (d == 0) begin
            bus4.move_valid = v; bus4.move_idx = i4; bus4.move_player = pl;
        end else begin
            bus3.move_valid = v; bus3.move_idx = i4; bus3.move_player = pl;
        end
    endtask

    task automatic push(input int d, input exp_t e);
        if (d == 0) q4.push_back(e);
        else        q3.push_back(e);
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q4.size() : q3.size();
    endfunction

    task automatic wait_resp(input int d);
        for (int w = 0; w < 6 && qsize(d) != 0; w++) @(negedge clock);
        check("resp_timeout", 64'(qsize(d)), 64'd0);
        if (d == 0) q4.delete();
        else        q3.delete();
    endtask

    // Monitor: pops one expectation per ack/err pulse.
    task automatic mon(input int d, input logic ack, input logic err, input logic [1:0] ec,
                       input logic [63:0] brd, input int cnt, input logic ns, input logic [1:0] trn);
        exp_t e;
        int   sz;
        if (!(ack || err)) return;
        resp_cnt[d]++;
        check("ack_err_exclusive", 64'(ack && err), 64'd0);
        sz = qsize(d);
        check("resp_expected", 64'(sz != 0), 64'd1);
        if (sz == 0) return;
        if (d == 0) e = q4.pop_front();
        else        e = q3.pop_front();
        check("resp_is_ack", 64'(ack), 64'(e.is_ack));
        if (err) check("err_code", 64'(ec), 64'(e.code));
        check("latency", 64'(cyc - e.hs), 64'(e.lat));
        check("board", brd, e.brd);
        check("occupied_cnt", 64'(cnt), 64'(e.cnt));
        check("no_space", 64'(ns), 64'(e.ns));
        check("turn", 64'(trn), 64'(e.trn));
        check("no_space_inv", 64'(ns), 64'(cnt == ncells(d)));
    endtask

    always @(negedge clock) mon(0, bus4.move_ack, bus4.move_err, bus4.err_code,
                                64'(board4), int'(cnt4), ns4, turn4);
    always @(negedge clock) mon(1, bus3.move_ack, bus3.move_err, bus3.err_code,
                                64'(board3), int'(cnt3), ns3, turn3);

    task automatic do_move(input int d, input int idx, input logic [1:0] pl);
        exp_t e;
        int   w;
        e.is_ack = 1'b0;
        e.code   = 2'b00;
        if (idx >= ncells(d) || pl == 2'b00 || pl == 2'b11) e.code = 2'b11;
        else if (pl != mturn[d])                             e.code = 2'b10;
        else if (mb[d][idx] != 2'b00)                        e.code = 2'b01;
        else begin
            e.is_ack   = 1'b1;
            mb[d][idx] = pl;
            mcnt[d]++;
            mturn[d]   = (pl == X) ? O : X;
            mlast[d]   = idx;
            mhist[d]   = 1'b1;
        end
        e.lat = e.is_ack ? 2 : 1;
        snap(d, e);
        @(negedge clock);
        w = 0;
        while (rdy(d) !== 1'b1 && w < 10) begin
            @(negedge clock);
            w++;
        end
        check("ready_before_move", 64'(rdy(d)), 64'd1);
        e.hs = cyc + 1;
        push(d, e);
        drive(d, 1'b1, idx, pl);
        @(negedge clock);
        drive(d, 1'b0, 0, 2'b00);
        wait_resp(d);
    endtask

    task automatic do_clear(input int d);
        @(negedge clock);
        if (d == 0) clear4 = 1'b1; else clear3 = 1'b1;
        @(negedge clock);
        if (d == 0) clear4 = 1'b0; else clear3 = 1'b0;
        reset_model(d);
        check("clear_board", (d == 0) ? 64'(board4) : 64'(board3), 64'd0);
        check("clear_cnt", (d == 0) ? 64'(cnt4) : 64'(cnt3), 64'd0);
        check("clear_turn", (d == 0) ? 64'(turn4) : 64'(turn3), 64'(X));
        check("clear_no_space", (d == 0) ? 64'(ns4) : 64'(ns3), 64'd0);
        check("clear_ready", 64'(rdy(d)), 64'd1);
    endtask

`ifdef TRACKER_UNDO_EN
    task automatic do_undo();
        exp_t e;
        e.is_ack = 1'b0;
        e.code   = 2'b11;
        if (mhist[0]) begin
            e.is_ack         = 1'b1;
            e.code           = 2'b00;
            mb[0][mlast[0]]  = 2'b00;
            mcnt[0]--;
            mturn[0]         = (mturn[0] == X) ? O : X;
            mhist[0]         = 1'b0;
        end
        e.lat = 0;
        snap(0, e);
        @(negedge clock);
        e.hs = cyc + 1;
        push(0, e);
        undo4 = 1'b1;
        @(negedge clock);
        undo4 = 1'b0;
        wait_resp(0);
    endtask
`endif

    initial begin
        int r;
        reset = 1'b0;
        clear4 = 1'b0; clear3 = 1'b0; undo4 = 1'b0; undo3 = 1'b0;
        drive(0, 1'b0, 0, 2'b00);
        drive(1, 1'b0, 0, 2'b00);
        resp_cnt[0] = 0; resp_cnt[1] = 0;
        reset_model(0);
        reset_model(1);
        repeat (2) @(negedge clock);
        check("rst_board", 64'(board4), 64'd0);
        check("rst_cnt", 64'(cnt4), 64'd0);
        check("rst_turn", 64'(turn4), 64'(X));
        check("rst_no_space", 64'(ns4), 64'd0);
        check("rst_ack", 64'(bus4.move_ack), 64'd0);
        check("rst_err", 64'(bus4.move_err), 64'd0);
        check("rst_err_code", 64'(bus4.err_code), 64'd0);
        check("rst_ready", 64'(bus4.move_ready), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        check("ready_after_reset", 64'(bus4.move_ready), 64'd1);

        // Single legal move, then occupied and wrong-turn rejections.
        do_move(0, 5, X);
        check("cell5_is_x", 64'(board4[11:10]), 64'(X));
        do_move(0, 5, O);
        do_move(0, 6, X);
        do_clear(0);

        // Fill the 4x4 board; requests are then swallowed until clear.
        for (int k = 0; k < 16; k++) do_move(0, k, (k % 2 == 0) ? X : O);
        @(negedge clock);
        check("full_ready_low", 64'(bus4.move_ready), 64'd0);
        r = resp_cnt[0];
        drive(0, 1'b1, 3, X);
        repeat (5) @(negedge clock);
        drive(0, 1'b0, 0, 2'b00);
        check("full_no_resp", 64'(resp_cnt[0] - r), 64'd0);
        check("full_no_space", 64'(ns4), 64'd1);
        do_clear(0);

        // 3x3: malformed requests, then fill.
        do_move(1, 9, X);
        do_move(1, 0, 2'b11);
        do_move(1, 0, 2'b00);
        for (int k = 0; k < 9; k++) do_move(1, k, (k % 2 == 0) ? X : O);
        @(negedge clock);
        check("dim3_full_ready", 64'(bus3.move_ready), 64'd0);
        check("dim3_full_cnt", 64'(cnt3), 64'd9);

`ifdef TRACKER_UNDO_EN
        for (int k = 0; k < 16; k++) do_move(0, 15 - k, (k % 2 == 0) ? X : O);
        do_undo();
        check("undo_ready", 64'(bus4.move_ready), 64'd1);
        check("undo_cell0", 64'(board4[1:0]), 64'd0);
        do_undo();
        do_clear(0);
`else
        r = resp_cnt[0];
        @(negedge clock);
        undo4 = 1'b1;
        repeat (2) @(negedge clock);
        undo4 = 1'b0;
        repeat (2) @(negedge clock);
        check("undo_ignored_resp", 64'(resp_cnt[0] - r), 64'd0);
        check("undo_ignored_board", 64'(board4), 64'd0);
`endif

        // Clear during CHECK drops the move silently.
        do_move(0, 0, X);
        @(negedge clock);
        r = resp_cnt[0];
        drive(0, 1'b1, 2, O);
        @(negedge clock);
        drive(0, 1'b0, 0, 2'b00);
        clear4 = 1'b1;
        @(negedge clock);
        clear4 = 1'b0;
        reset_model(0);
        repeat (4) @(negedge clock);
        check("clr_check_no_resp", 64'(resp_cnt[0] - r), 64'd0);
        check("clr_check_board", 64'(board4), 64'd0);
        check("clr_check_cnt", 64'(cnt4), 64'd0);

        // Async reset while the second move sits in COMMIT.
        do_move(0, 0, X);
        @(negedge clock);
        drive(0, 1'b1, 1, O);
        @(negedge clock);
        drive(0, 1'b0, 0, 2'b00);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("arst_board", 64'(board4), 64'd0);
        check("arst_cnt", 64'(cnt4), 64'd0);
        check("arst_turn", 64'(turn4), 64'(X));
        check("arst_no_space", 64'(ns4), 64'd0);
        check("arst_ready", 64'(bus4.move_ready), 64'd0);
        check("arst_ack", 64'(bus4.move_ack), 64'd0);
        check("arst_dim3_board", 64'(board3), 64'd0);
        reset_model(0);
        reset_model(1);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("post_rst_ack", 64'(bus4.move_ack), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/board_occupancy_tracker.md
Name: board_occupancy_tracker

Overview:
Registered, parametrised board store for an N x N tic-tac-toe board (default 4x4, 16 cells). It succeeds the purely combinational full-board detector. Accepts player moves over a valid/ready handshake, checks legality, enforces turn order, and writes each accepted move into the board register. Maintains an occupancy count and a registered no_space flag that feed the game controller and the win/draw logic.

Parameters:
BOARD_DIM, 4, cells per row/column; legal range 3..8.
CELLS, BOARD_DIM*BOARD_DIM, derived localparam; not overridable.
IDX_W, $clog2(CELLS), derived localparam; cell index width.

Ports:
clock  in  1  system clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset.
clear  in  1  synchronous new-game request; highest priority after reset.
move_valid  in  1  move request present.
move_idx  in  IDX_W  target cell; row-major, 0 = top-left.
move_player  in  2  01 = X, 10 = O; 00 and 11 are illegal.
move_ready  out  1  block can accept a move this cycle.
move_ack  out  1  one-cycle pulse: move committed.
move_err  out  1  one-cycle pulse: move rejected.
err_code  out  2  01 occupied, 10 wrong turn, 11 bad index/player; held until next ack/err.
board  out  2*CELLS  cell k at bits [2k+1:2k]; 00 empty, 01 X, 10 O.
occupied_cnt  out  IDX_W+1  number of non-empty cells.
turn  out  2  player expected next (01/10).
no_space  out  1  registered; high when occupied_cnt == CELLS.
undo_req  in  1  undo last move; used only with TRACKER_UNDO_EN, otherwise ignored.

Behaviour:
- Reset (reset=0, async):
  - board=0, occupied_cnt=0, turn=01, no_space=0.
  - move_ack=0, move_err=0, err_code=00, move_ready=0, FSM=IDLE.
  - move_ready rises the first cycle after reset deasserts.
- FSM states: IDLE, CHECK, COMMIT, FULL.
- IDLE:
  - move_ready=1.
  - On move_valid & move_ready: latch idx/player, go to CHECK. move_ready drops the next cycle.
- CHECK: evaluate in fixed priority:
  1. move_idx >= CELLS, or move_player in {00,11} -> err 11.
  2. move_player != turn -> err 10.
  3. Target cell non-zero -> err 01.
  - Illegal: pulse move_err, return to IDLE.
  - Legal: go to COMMIT.
- COMMIT:
  - Write the cell, increment occupied_cnt, toggle turn, pulse move_ack.
  - If the new count == CELLS: set no_space in the same edge as the count update and go to FULL; otherwise go to IDLE.
- Latency: handshake at cycle T; move_err at T+1 (CHECK cycle); move_ack and updated board/count/no_space visible at T+2. At most one move in flight.
- FULL:
  - move_ready=0, no_space=1.
  - Requests are not accepted and produce no err.
  - Exits only via clear or reset.
- clear=1 in any state:
  - Next edge: board=0, count=0, turn=01, no_space=0, err_code=00, state=IDLE.
  - A pending move in CHECK/COMMIT is discarded: no ack, no err.
  - clear together with a handshake: the handshake is ignored.
- Invariants:
  - occupied_cnt equals the popcount of non-zero cells at all times.
  - no_space == (occupied_cnt == CELLS).
  - move_ack and move_err are never high in the same cycle.
- move_valid held with unchanged data after a completed move is treated as a new request.

Optional Feature:
TRACKER_UNDO_EN
- Defined:
  - Block keeps a one-deep history: the index of the last committed move plus a history-valid bit.
  - undo_req in IDLE or FULL with history valid: next edge clears that cell, decrements occupied_cnt, toggles turn, clears no_space, goes to IDLE, invalidates history, pulses move_ack. Only one undo is possible between moves.
  - undo_req with no history: pulse move_err, err_code=11.
  - undo_req in CHECK/COMMIT: ignored.
  - undo_req together with a move handshake in IDLE: undo wins and the move is not accepted.
  - clear invalidates history.
- Undefined: undo_req has no effect; no history registers are built.

Test Plan:
1. Reset, then move (idx 5, X) -> ack at T+2, board[11:10]=01, occupied_cnt=1, turn=10, no_space=0.
2. Move X at idx 5, then O at idx 5 -> move_err at T+1, err_code=01, board unchanged; then X at idx 6 -> err_code=10.
3. BOARD_DIM=4: 16 alternating legal moves -> no_space rises on the 16th ack edge, occupied_cnt=16, move_ready=0; a 17th request gets no ack/err; clear -> count=0, no_space=0, turn=01.
4. BOARD_DIM=3: move idx 9, or player 11 -> err_code=11; 9 legal moves -> no_space=1 with count=9.
5. clear asserted during CHECK of a legal move -> no ack, cell stays 00, count=0; async reset mid-COMMIT -> all outputs at reset values immediately.
6. With TRACKER_UNDO_EN: fill to FULL, undo_req -> last cell 00, count=CELLS-1, no_space=0, move_ready=1, ack pulse; a second undo_req -> move_err, err_code=11.
